if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the program counter, issues word fetches to instruction memory over a req/ready handshake, and presents the fetched instruction with its PC+4 to the IF/ID pipeline register. The block absorbs instruction-memory wait states, downstream stalls, and branch/jump redirects from ID.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: downstream advance enable, the same signal that drives the IF/ID enable. 1 = IF/ID captures this cycle.
- `redirect` in 1: branch/jump taken, from ID; single-cycle pulse.
- `redirect_pc` in 32: target PC; bits [1:0] ignored and forced to 0.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch word address, always with bits [1:0] = 0.
- `imem_ready` in 1: read data valid this cycle for the outstanding request.
- `imem_rdata` in 32: instruction word.
- `IF_pc_plus_4` out 32: PC of the presented instruction + 4, modulo 2^32.
- `IF_ins` out 32: presented instruction.
- `IF_valid` out 1: `IF_ins` and `IF_pc_plus_4` are meaningful this cycle.

## Operation
- Registers:
  - `pc`: next instruction to hand downstream.
  - `fetch_addr`: address of the outstanding request.
  - `ibuf`: 32-bit held instruction.
  - `state` ∈ {REQ, HOLD, FLUSH}.
- Reset: `pc` = `fetch_addr` = RESET_PC, `ibuf` = 0, `state` = REQ. While `rst` is high, `imem_req` = 0, `IF_valid` = 0, `IF_ins` = 0, and `IF_pc_plus_4` = RESET_PC+4.
- Memory protocol:
  - `imem_req` stays high with `imem_addr` stable until the cycle `imem_ready` = 1.
  - The request completes in that cycle.
  - `imem_ready` is ignored when `imem_req` = 0.
- `IF_pc_plus_4` = `pc` + 4 in all states.
- REQ state:
  - `imem_req` = 1, `imem_addr` = `fetch_addr`.
  - `IF_valid` = `imem_ready` & ~`redirect`; `IF_ins` = `imem_rdata`.
  - `IF_valid` & `en`: `pc` and `fetch_addr` ← `pc`+4; stay in REQ.
  - `IF_valid` & ~`en`: `ibuf` ← `imem_rdata`; go to HOLD.
  - Otherwise: hold all registers.
- HOLD state:
  - `imem_req` = 0; `IF_valid` = ~`redirect`; `IF_ins` = `ibuf`.
  - `en` & ~`redirect`: `pc` and `fetch_addr` ← `pc`+4; go to REQ.
- FLUSH state (a wrong-path request is still outstanding):
  - `imem_req` = 1, `imem_addr` = `fetch_addr` (the stale address).
  - `IF_valid` = 0; `IF_ins` = `imem_rdata` (don't-care).
  - `imem_ready`: discard the data, `fetch_addr` ← `pc`, go to REQ.
  - `en` has no effect in FLUSH.
- Redirect has priority over every other event, in any state:
  - `pc` ← {`redirect_pc`[31:2], 2'b00}.
  - `IF_valid` is forced to 0 that cycle, so nothing is consumed.
  - State REQ with `imem_ready` = 0: go to FLUSH, `fetch_addr` unchanged.
  - State REQ with `imem_ready` = 1, or state HOLD: `fetch_addr` ← new `pc`, go to REQ.
  - State FLUSH: update `pc` only, stay in FLUSH. If `imem_ready` = 1 in the same cycle, `fetch_addr` ← new `pc` and go to REQ.
- `rst` overrides `redirect`, `en` and `imem_ready`. Reset mid-request abandons that request; instruction memory is reset by the same `rst`.

## Timing
- Zero-wait memory (`imem_ready` = 1 in the request cycle): one instruction per cycle, `IF_valid` continuously high while `en` = 1.
- First fetch after reset deasserts: `imem_req` = 1 at `imem_addr` = RESET_PC in the first cycle with `rst` = 0.
- N wait states: `IF_valid` rises N cycles after the request starts.
- Redirect penalty with zero-wait memory: 1 cycle with `IF_valid` = 0; the target is fetched in the next cycle.
- Redirect during an outstanding request: the target request starts in the cycle after the stale request's `imem_ready`.
- Redirect in the same cycle as `IF_valid` would have been 1: that instruction is dropped, never presented.
- Stall release from HOLD: the next request issues in the cycle after `en` returns high. Throughput loss is 1 cycle per stall episode.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag raised.

## Test plan
- **Reset, zero-wait memory, `en` = 1:** hold `rst` 2 cycles then release, RESET_PC = 0. Expect `imem_addr` = 0, 4, 8, 12 on consecutive cycles; `IF_pc_plus_4` = 4, 8, 12, 16; `IF_valid` = 1 each cycle; `IF_ins` equals the memory word.
- **Wait states:** `imem_ready` delayed 3 cycles per request. Expect `imem_addr` stable at 0 for 4 cycles and `IF_valid` = 1 only in the 4th; next request at 4.
- **Stall:** `en` = 0 for 3 cycles while the instruction at 8 returns. Expect state HOLD, `IF_ins` held at `mem`[8], `imem_req` = 0. On `en` = 1, address 12 is requested next cycle.
- **Redirect, zero-wait:** `redirect` with `redirect_pc` = 32'h0000_0103 while presenting 0x10. Expect `IF_valid` = 0 that cycle, then `imem_addr` = 0x100, `IF_pc_plus_4` = 0x104.
- **Redirect while stalled on memory:** redirect to 0x200 while the request to 0x40 waits 2 more cycles. Expect `imem_addr` to stay 0x40 until ready, the data discarded (`IF_valid` = 0), then a request to 0x200.
- **Reset mid-operation and wrap:** assert `rst` during HOLD. Expect `IF_valid` = 0 and `imem_req` = 0 immediately, then a restart at RESET_PC. With RESET_PC = 32'hFFFF_FFFC, expect the second fetch at 0 and `IF_pc_plus_4` = 0 for the first instruction.

Source files
------------

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - MIPS instruction-fetch stage: PC, imem handshake, stall hold and redirect flush.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_pc_plus_4,
  output logic [31:0] IF_ins,
  output logic        IF_valid
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] ibuf_q, ibuf_d;
  logic [31:0] pc_plus_4;
  logic [31:0] redirect_target;
  logic        valid;

  assign pc_plus_4       = pc_q + 32'd4;
  assign redirect_target = redirect_pc & ~32'd3;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    ibuf_d       = ibuf_q;
    valid        = 1'b0;
    imem_req     = 1'b0;
    imem_addr    = fetch_addr_q;
    IF_ins       = imem_rdata;
    IF_pc_plus_4 = pc_plus_4;

    case (state_q)
      S_REQ: begin
        imem_req = 1'b1;
        valid    = imem_ready & ~redirect;
        if (redirect) begin
          pc_d = redirect_target;
          // A request still in flight must drain before the target can be fetched.
          if (imem_ready) fetch_addr_d = redirect_target;
          else            state_d      = S_FLUSH;
        end else if (valid) begin
          if (en) begin
            pc_d         = pc_plus_4;
            fetch_addr_d = pc_plus_4;
          end else begin
            ibuf_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        valid  = ~redirect;
        IF_ins = ibuf_q;
        if (redirect) begin
          pc_d         = redirect_target;
          fetch_addr_d = redirect_target;
          state_d      = S_REQ;
        end else if (en) begin
          pc_d         = pc_plus_4;
          fetch_addr_d = pc_plus_4;
          state_d      = S_REQ;
        end
      end
      S_FLUSH: begin
        imem_req = 1'b1;
        if (redirect) pc_d = redirect_target;
        if (imem_ready) begin
          fetch_addr_d = redirect ? redirect_target : pc_q;
          state_d      = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // Reset masks every output immediately, even before the registers settle.
    if (rst) begin
      valid        = 1'b0;
      imem_req     = 1'b0;
      IF_ins       = 32'd0;
      IF_pc_plus_4 = RESET_PC + 32'd4;
      pc_d         = RESET_PC;
      fetch_addr_d = RESET_PC;
      ibuf_d       = 32'd0;
      state_d      = S_REQ;
    end

    IF_valid = valid;
  end

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    pc_q         <= pc_d;
    fetch_addr_q <= fetch_addr_d;
    ibuf_q       <= ibuf_d;
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch: vector table, wrap sequence, randomized flow model.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst, en, redirect, imem_ready;
  logic [31:0] redirect_pc, imem_rdata, imem_rdata2;
  logic        imem_req, IF_valid, imem_req2, IF_valid2;
  logic [31:0] imem_addr, IF_pc_plus_4, IF_ins;
  logic [31:0] imem_addr2, IF_pc_plus_42, IF_ins2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .IF_pc_plus_4(IF_pc_plus_4), .IF_ins(IF_ins),
    .IF_valid(IF_valid)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata2), .IF_pc_plus_4(IF_pc_plus_42), .IF_ins(IF_ins2),
    .IF_valid(IF_valid2)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic rd,
                       input logic [31:0] rp, input logic rdy);
    @(negedge clk);
    rst = r; en = e; redirect = rd; redirect_pc = rp; imem_ready = rdy;
    #1;
    imem_rdata  = memf(imem_addr);
    imem_rdata2 = memf(imem_addr2);
    #1;
  endtask

  typedef struct {
    logic        rst, en, redir;
    logic [31:0] rpc;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc4;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic rd, input logic [31:0] rp,
                     input logic rdy, input logic xreq, input logic [31:0] xaddr,
                     input logic xvalid, input logic [31:0] xpc4);
    vec_t v;
    v.rst = r; v.en = e; v.redir = rd; v.rpc = rp; v.ready = rdy;
    v.exp_req = xreq; v.exp_addr = xaddr; v.exp_valid = xvalid; v.exp_pc4 = xpc4;
    vecs.push_back(v);
  endtask

  logic [31:0] model_pc, prev_addr;
  logic        held, prev_pend;
  int          wleft, starve;
  logic        r_rst, r_en, r_rd, r_rdy;
  logic [31:0] r_rpc;

  initial begin
    rst = 1'b1; en = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; imem_ready = 1'b0;
    imem_rdata = 32'd0; imem_rdata2 = 32'd0;

    //   rst en rd rpc           rdy  req addr          vld pc4
    add(1, 1, 0, 32'h0,        0,   0, 32'h0,        0, 32'h4);
    add(1, 1, 0, 32'h0,        1,   0, 32'h0,        0, 32'h4);
    add(0, 1, 0, 32'h0,        1,   1, 32'h0,        1, 32'h4);
    add(0, 1, 0, 32'h0,        1,   1, 32'h4,        1, 32'h8);
    add(0, 1, 0, 32'h0,        1,   1, 32'h8,        1, 32'hC);
    add(0, 1, 0, 32'h0,        1,   1, 32'hC,        1, 32'h10);
    add(0, 1, 1, 32'h103,      1,   1, 32'h10,       0, 32'h14);
    add(0, 1, 0, 32'h0,        1,   1, 32'h100,      1, 32'h104);
    add(0, 1, 0, 32'h0,        0,   1, 32'h104,      0, 32'h108);
    add(0, 1, 0, 32'h0,        0,   1, 32'h104,      0, 32'h108);
    add(0, 1, 0, 32'h0,        0,   1, 32'h104,      0, 32'h108);
    add(0, 1, 0, 32'h0,        1,   1, 32'h104,      1, 32'h108);
    add(0, 0, 0, 32'h0,        1,   1, 32'h108,      1, 32'h10C);
    add(0, 0, 0, 32'h0,        1,   0, 32'h0,        1, 32'h10C);
    add(0, 0, 0, 32'h0,        0,   0, 32'h0,        1, 32'h10C);
    add(0, 1, 0, 32'h0,        1,   0, 32'h0,        1, 32'h10C);
    add(0, 1, 1, 32'h200,      0,   1, 32'h10C,      0, 32'h110);
    add(0, 1, 0, 32'h0,        0,   1, 32'h10C,      0, 32'h204);
    add(0, 1, 0, 32'h0,        1,   1, 32'h10C,      0, 32'h204);
    add(0, 1, 0, 32'h0,        1,   1, 32'h200,      1, 32'h204);
    add(0, 0, 0, 32'h0,        1,   1, 32'h204,      1, 32'h208);
    add(0, 1, 1, 32'h300,      0,   0, 32'h0,        0, 32'h208);
    add(0, 0, 0, 32'h0,        1,   1, 32'h300,      1, 32'h304);
    add(1, 1, 0, 32'h0,        1,   0, 32'h0,        0, 32'h4);
    add(0, 1, 0, 32'h0,        1,   1, 32'h0,        1, 32'h4);
    add(0, 1, 0, 32'h0,        1,   1, 32'h4,        1, 32'h8);
    add(0, 1, 1, 32'h42,       0,   1, 32'h8,        0, 32'hC);
    add(0, 1, 1, 32'h81,       1,   1, 32'h8,        0, 32'h44);
    add(0, 1, 0, 32'h0,        1,   1, 32'h80,       1, 32'h84);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
      chk($sformatf("vec%0d req", i), {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
      chk($sformatf("vec%0d valid", i), {31'd0, IF_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d pc4", i), IF_pc_plus_4, vecs[i].exp_pc4);
      if (vecs[i].exp_req) chk($sformatf("vec%0d addr", i), imem_addr, vecs[i].exp_addr);
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d ins", i), IF_ins, memf(vecs[i].exp_pc4 - 32'd4));
      else if (vecs[i].rst)
        chk($sformatf("vec%0d ins_rst", i), IF_ins, 32'd0);
    end

    // PC wrap on an instance reset to the top word of the address space
    drive(1, 1, 0, 32'h0, 1);
    drive(1, 1, 0, 32'h0, 1);
    chk("wrap rst pc4", IF_pc_plus_42, 32'h0000_0000);
    drive(0, 1, 0, 32'h0, 1);
    chk("wrap addr0", imem_addr2, 32'hFFFF_FFFC);
    chk("wrap pc4_0", IF_pc_plus_42, 32'h0000_0000);
    chk("wrap valid0", {31'd0, IF_valid2}, 32'd1);
    chk("wrap ins0", IF_ins2, memf(32'hFFFF_FFFC));
    drive(0, 1, 0, 32'h0, 1);
    chk("wrap addr1", imem_addr2, 32'h0000_0000);
    chk("wrap pc4_1", IF_pc_plus_42, 32'h0000_0004);
    chk("wrap ins1", IF_ins2, memf(32'h0));

    // Randomized run against an instruction-flow model
    drive(1, 0, 0, 32'h0, 0);
    drive(1, 0, 0, 32'h0, 0);
    model_pc = 32'h0; held = 1'b0; prev_pend = 1'b0; prev_addr = 32'h0;
    wleft = $urandom_range(0, 3); starve = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_en  = ($urandom_range(0, 3) != 0);
      r_rd  = ($urandom_range(0, 9) == 0);
      r_rpc = $urandom;
      @(negedge clk);
      rst = r_rst; en = r_en; redirect = r_rd; redirect_pc = r_rpc;
      #1;
      if (imem_req) begin
        r_rdy = (wleft == 0);
        if (r_rdy) wleft = $urandom_range(0, 3);
        else       wleft--;
      end else begin
        r_rdy = $urandom_range(0, 1) == 1;
      end
      if (r_rst) wleft = $urandom_range(0, 3);
      imem_ready = r_rdy;
      imem_rdata = memf(imem_addr);
      #1;
      if (r_rst) begin
        chk("rnd rst req", {31'd0, imem_req}, 32'd0);
        chk("rnd rst valid", {31'd0, IF_valid}, 32'd0);
        chk("rnd rst pc4", IF_pc_plus_4, 32'h4);
        model_pc = 32'h0; held = 1'b0; prev_pend = 1'b0; starve = 0;
      end else begin
        chk("rnd pc4", IF_pc_plus_4, model_pc + 32'd4);
        chk("rnd addr align", {30'd0, imem_addr[1:0]}, 32'd0);
        if (r_rd) chk("rnd redirect kills valid", {31'd0, IF_valid}, 32'd0);
        if (held && !r_rd) chk("rnd held still valid", {31'd0, IF_valid}, 32'd1);
        if (prev_pend) begin
          chk("rnd req stays high", {31'd0, imem_req}, 32'd1);
          chk("rnd addr stable", imem_addr, prev_addr);
        end
        if (IF_valid) chk("rnd ins", IF_ins, memf(model_pc));
        if (r_en && !r_rd && !IF_valid) starve++;
        else starve = 0;
        chk("rnd progress bound", {31'd0, starve > 16}, 32'd0);
        prev_pend = imem_req && !r_rdy;
        prev_addr = imem_addr;
        if (r_rd) begin
          model_pc = r_rpc & ~32'd3; held = 1'b0; starve = 0;
        end else if (IF_valid && r_en) begin
          model_pc = model_pc + 32'd4; held = 1'b0;
        end else begin
          held = IF_valid;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
